// File: rtl/wisard_serial_tx_pkg.sv
// Shared definitions for the serial WiSARD transmitter: FSM state encoding
// and the bit-counter width helper.
package wisard_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_EOP   = 2'd3
  } state_e;

  // A one-bit word still needs a one-bit counter.
  function automatic int cnt_width(input int aw);
    return (aw > 32'sd1) ? $clog2(aw) : 32'sd1;
  endfunction

endpackage

// File: rtl/wisard_serial_tx_piso.sv
// Loadable parallel-in/serial-out register, LSB first, zero-filled so the
// serial bit idles low once a word has fully drained.
module wisard_piso
  import wisard_serial_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             bit_out,
  output logic             last_bit
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_r;
  logic [CNT_W-1:0] bit_cnt_r;

  // Load has priority so a prefetched word can follow the last bit directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_r   <= '0;
      bit_cnt_r <= '0;
    end else if (load) begin
      shreg_r   <= din;
      bit_cnt_r <= '0;
    end else if (shift) begin
      shreg_r   <= shreg_r >> 1'b1;
      bit_cnt_r <= (bit_cnt_r == LAST_CNT) ? CNT_W'(0) : bit_cnt_r + CNT_W'(1);
    end else begin
      shreg_r   <= shreg_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  assign bit_out  = shreg_r[0];
  assign last_bit = (bit_cnt_r == LAST_CNT);

endmodule

// File: rtl/wisard_serial_tx.sv
// Serialises one RAM address per handshake, LSB first, and frames each sample
// of N_RAMS addresses with sop/sink_valid/eop for the serial WiSARD core.
module wisard_serial_tx
  import wisard_serial_tx_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int INDEX_WIDTH   = 4,
  parameter int N_RAMS        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] in_addr,
  output logic                     sop,
  output logic                     sink_valid,
  output logic                     addr_bit,
  output logic                     eop,
  output logic [INDEX_WIDTH-1:0]   src_index,
  output logic                     busy
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX  = INDEX_WIDTH'(N_RAMS - 1);
  localparam logic                   MULTI_RAM = (N_RAMS > 32'sd1);

  state_e                 state_r;
  logic [INDEX_WIDTH-1:0] ram_cnt_r;
  logic [INDEX_WIDTH-1:0] src_index_r;
  logic                   sop_r;
  logic                   sink_valid_r;
  logic                   eop_r;
  logic                   busy_r;

  logic                   in_ready_s;
  logic [INDEX_WIDTH-1:0] load_idx_s;
  logic                   load_s;
  logic                   shift_s;
  logic                   last_bit_s;
  logic                   addr_bit_s;

  // Acceptance window and the index the accepted word will carry. In SHIFT the
  // counter advances on the same edge, so a prefetched word is the next index.
  always_comb begin
    in_ready_s = 1'b0;
    load_idx_s = ram_cnt_r;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = 1'b1;
        load_idx_s = ram_cnt_r;
      end
      ST_SHIFT: begin
        in_ready_s = last_bit_s && (ram_cnt_r != '0) && (ram_cnt_r != LAST_IDX);
        load_idx_s = ram_cnt_r + INDEX_WIDTH'(1);
      end
      ST_GAP: begin
        in_ready_s = MULTI_RAM;
        load_idx_s = ram_cnt_r;
      end
      ST_EOP: begin
        in_ready_s = 1'b1;
        load_idx_s = '0;
      end
      default: begin
        in_ready_s = 1'b0;
        load_idx_s = '0;
      end
    endcase
  end

  assign load_s   = in_ready_s && in_valid;
  assign shift_s  = (state_r == ST_SHIFT) && !load_s;
  assign in_ready = in_ready_s;

  wisard_piso #(
    .WIDTH (ADDRESS_WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .shift    (shift_s),
    .din      (in_addr),
    .bit_out  (addr_bit_s),
    .last_bit (last_bit_s)
  );

  // Framing FSM; every framing output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      ram_cnt_r    <= '0;
      src_index_r  <= '0;
      sop_r        <= 1'b0;
      sink_valid_r <= 1'b0;
      eop_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      sink_valid_r <= load_s;
      sop_r        <= load_s && (load_idx_s == '0);
      eop_r        <= 1'b0;
      if (load_s) begin
        src_index_r <= load_idx_s;
        busy_r      <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (load_s) state_r <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (last_bit_s) begin
            if (ram_cnt_r != LAST_IDX) ram_cnt_r <= ram_cnt_r + INDEX_WIDTH'(1);
            if (ram_cnt_r == '0) begin
              state_r <= ST_GAP;
            end else if (ram_cnt_r == LAST_IDX) begin
              state_r <= ST_EOP;
              eop_r   <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r <= load_s ? ST_SHIFT : ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          // A single-RAM sample has no word 1 to wait for.
          if (!MULTI_RAM) begin
            state_r <= ST_EOP;
            eop_r   <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            state_r <= load_s ? ST_SHIFT : ST_IDLE;
          end
        end
        ST_EOP: begin
          ram_cnt_r <= '0;
          state_r   <= load_s ? ST_SHIFT : ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign sop        = sop_r;
  assign sink_valid = sink_valid_r;
  assign addr_bit   = addr_bit_s;
  assign eop        = eop_r;
  assign src_index  = src_index_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_wisard_serial_tx.sv
// Directed per-cycle vectors with hand-computed expectations for two builds:
// AW=4/N_RAMS=3 and the degenerate AW=1/N_RAMS=1.
module tb_wisard_serial_tx;

  typedef struct packed {
    logic       r;
    logic       v;
    logic [3:0] a;
    logic       rdy;
    logic       sop;
    logic       sv;
    logic       b;
    logic       eop;
    logic       busy;
    logic [3:0] idx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_a, valid_a, ready_a, sop_a, sv_a, bit_a, eop_a, busy_a;
  logic [3:0] addr_a;
  logic [1:0] idx_a;
  logic       rst_b, valid_b, ready_b, sop_b, sv_b, bit_b, eop_b, busy_b;
  logic [0:0] addr_b;
  logic [0:0] idx_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vec_a[$];
  vec_t vec_b[$];

  always #5 clk = ~clk;

  wisard_serial_tx #(.ADDRESS_WIDTH(4), .INDEX_WIDTH(2), .N_RAMS(3)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(valid_a), .in_ready(ready_a), .in_addr(addr_a),
    .sop(sop_a), .sink_valid(sv_a), .addr_bit(bit_a), .eop(eop_a),
    .src_index(idx_a), .busy(busy_a)
  );

  wisard_serial_tx #(.ADDRESS_WIDTH(1), .INDEX_WIDTH(1), .N_RAMS(1)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(valid_b), .in_ready(ready_b), .in_addr(addr_b),
    .sop(sop_b), .sink_valid(sv_b), .addr_bit(bit_b), .eop(eop_b),
    .src_index(idx_b), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(input bit to_b, input logic r, input logic v, input logic [3:0] a,
                     input logic rdy, input logic sop, input logic sv, input logic b,
                     input logic eop, input logic busy, input logic [3:0] idx);
    vec_t t;
    t = '{r, v, a, rdy, sop, sv, b, eop, busy, idx};
    if (to_b) vec_b.push_back(t);
    else      vec_a.push_back(t);
  endtask

  initial begin
    rst_a = 1'b1; valid_a = 1'b0; addr_a = 4'h0;
    rst_b = 1'b1; valid_b = 1'b0; addr_b = 1'b0;

    //        r  v  addr  rdy sop sv bit eop busy idx
    // Sample 1: 0xA, 0x3, 0x5 with valid held high; 0xF is noise while shifting.
    add(0, 0, 1, 4'hA, 1, 0, 0, 0, 0, 0, 4'd0);
    add(0, 0, 1, 4'hF, 0, 1, 1, 0, 0, 1, 4'd0);
    add(0, 0, 1, 4'hF, 0, 0, 0, 1, 0, 1, 4'd0);
    add(0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 1, 4'd0);
    add(0, 0, 1, 4'hF, 0, 0, 0, 1, 0, 1, 4'd0);
    add(0, 0, 1, 4'h3, 1, 0, 0, 0, 0, 1, 4'd0);
    add(0, 0, 1, 4'hF, 0, 0, 1, 1, 0, 1, 4'd1);
    add(0, 0, 1, 4'hF, 0, 0, 0, 1, 0, 1, 4'd1);
    add(0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 1, 4'd1);
    add(0, 0, 1, 4'h5, 1, 0, 0, 0, 0, 1, 4'd1);
    add(0, 0, 1, 4'hF, 0, 0, 1, 1, 0, 1, 4'd2);
    add(0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 1, 4'd2);
    add(0, 0, 1, 4'hF, 0, 0, 0, 1, 0, 1, 4'd2);
    add(0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 1, 4'd2);
    // EOP cycle also accepts word 0 of sample 2 (0x6, 0x9, 0xC).
    add(0, 0, 1, 4'h6, 1, 0, 0, 0, 1, 0, 4'd2);
    add(0, 0, 1, 4'hF, 0, 1, 1, 0, 0, 1, 4'd0);
    add(0, 0, 1, 4'hF, 0, 0, 0, 1, 0, 1, 4'd0);
    add(0, 0, 1, 4'hF, 0, 0, 0, 1, 0, 1, 4'd0);
    add(0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 1, 4'd0);
    add(0, 0, 1, 4'h9, 1, 0, 0, 0, 0, 1, 4'd0);
    add(0, 0, 1, 4'hF, 0, 0, 1, 1, 0, 1, 4'd1);
    add(0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 1, 4'd1);
    add(0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 1, 4'd1);
    // Starve from word 1's last bit for three cycles.
    add(0, 0, 0, 4'hF, 1, 0, 0, 1, 0, 1, 4'd1);
    add(0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 1, 4'd1);
    add(0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 1, 4'd1);
    add(0, 0, 1, 4'hC, 1, 0, 0, 0, 0, 1, 4'd1);
    add(0, 0, 1, 4'hF, 0, 0, 1, 0, 0, 1, 4'd2);
    add(0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 1, 4'd2);
    add(0, 0, 1, 4'hF, 0, 0, 0, 1, 0, 1, 4'd2);
    add(0, 0, 1, 4'hF, 0, 0, 0, 1, 0, 1, 4'd2);
    add(0, 0, 0, 4'hF, 1, 0, 0, 0, 1, 0, 4'd2);
    // Sample 3 (0x7, 0xB) is cut by reset during word 1 bit 2.
    add(0, 0, 1, 4'h7, 1, 0, 0, 0, 0, 0, 4'd2);
    add(0, 0, 1, 4'hF, 0, 1, 1, 1, 0, 1, 4'd0);
    add(0, 0, 1, 4'hF, 0, 0, 0, 1, 0, 1, 4'd0);
    add(0, 0, 1, 4'hF, 0, 0, 0, 1, 0, 1, 4'd0);
    add(0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 1, 4'd0);
    add(0, 0, 1, 4'hB, 1, 0, 0, 0, 0, 1, 4'd0);
    add(0, 0, 1, 4'hF, 0, 0, 1, 1, 0, 1, 4'd1);
    add(0, 0, 1, 4'hF, 0, 0, 0, 1, 0, 1, 4'd1);
    add(0, 1, 0, 4'hF, 0, 0, 0, 0, 0, 1, 4'd1);
    add(0, 0, 1, 4'h2, 1, 0, 0, 0, 0, 0, 4'd0);
    add(0, 0, 0, 4'hF, 0, 1, 1, 0, 0, 1, 4'd0);
    add(0, 0, 0, 4'hF, 0, 0, 0, 1, 0, 1, 4'd0);

    // One-bit words, one RAM per sample: bit, gap, eop; second sample offered at eop.
    add(1, 0, 1, 4'h1, 1, 0, 0, 0, 0, 0, 4'd0);
    add(1, 0, 1, 4'h1, 0, 1, 1, 1, 0, 1, 4'd0);
    add(1, 0, 1, 4'h1, 0, 0, 0, 0, 0, 1, 4'd0);
    add(1, 0, 1, 4'h0, 1, 0, 0, 0, 1, 0, 4'd0);
    add(1, 0, 0, 4'h0, 0, 1, 1, 0, 0, 1, 4'd0);
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 4'd0);
    add(1, 0, 0, 4'h0, 1, 0, 0, 0, 1, 0, 4'd0);
    add(1, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0, 4'd0);

    @(posedge clk); #1;
    foreach (vec_a[i]) begin
      rst_a = vec_a[i].r; valid_a = vec_a[i].v; addr_a = vec_a[i].a;
      #1;
      check_eq($sformatf("A c%0d in_ready", i),   32'(ready_a), 32'(vec_a[i].rdy));
      check_eq($sformatf("A c%0d sop", i),        32'(sop_a),   32'(vec_a[i].sop));
      check_eq($sformatf("A c%0d sink_valid", i), 32'(sv_a),    32'(vec_a[i].sv));
      check_eq($sformatf("A c%0d addr_bit", i),   32'(bit_a),   32'(vec_a[i].b));
      check_eq($sformatf("A c%0d eop", i),        32'(eop_a),   32'(vec_a[i].eop));
      check_eq($sformatf("A c%0d busy", i),       32'(busy_a),  32'(vec_a[i].busy));
      check_eq($sformatf("A c%0d src_index", i),  32'(idx_a),   32'(vec_a[i].idx));
      @(posedge clk); #1;
    end

    rst_b = 1'b1;
    @(posedge clk); #1;
    foreach (vec_b[i]) begin
      rst_b = vec_b[i].r; valid_b = vec_b[i].v; addr_b = vec_b[i].a[0];
      #1;
      check_eq($sformatf("B c%0d in_ready", i),   32'(ready_b), 32'(vec_b[i].rdy));
      check_eq($sformatf("B c%0d sop", i),        32'(sop_b),   32'(vec_b[i].sop));
      check_eq($sformatf("B c%0d sink_valid", i), 32'(sv_b),    32'(vec_b[i].sv));
      check_eq($sformatf("B c%0d addr_bit", i),   32'(bit_b),   32'(vec_b[i].b));
      check_eq($sformatf("B c%0d eop", i),        32'(eop_b),   32'(vec_b[i].eop));
      check_eq($sformatf("B c%0d busy", i),       32'(busy_b),  32'(vec_b[i].busy));
      check_eq($sformatf("B c%0d src_index", i),  32'(idx_b),   32'(vec_b[i].idx));
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
